// File: rtl/soc_arb_pkg.sv
// Shared types and constants for the per-slave transaction arbiter.
package soc_arb_pkg;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_t;

    localparam logic [1:0] MASTER_EXT   = 2'd0;
    localparam logic [1:0] MASTER_INSTR = 2'd1;
    localparam logic [1:0] MASTER_DATA  = 2'd2;

    function automatic logic [1:0] onehot_to_index(input logic [2:0] oh);
        logic [1:0] idx;
        idx = MASTER_EXT;
        if (oh[MASTER_DATA]) begin
            idx = MASTER_DATA;
        end else if (oh[MASTER_INSTR]) begin
            idx = MASTER_INSTR;
        end
        return idx;
    endfunction

endpackage

// File: rtl/soc_arb_winner_select.sv
// Combinational winner pick: master 0 priority with burst limit, round-robin between 1 and 2.
module soc_arb_winner_select
    import soc_arb_pkg::*;
(
    input  logic [2:0] requests,
    input  logic       rr_last,
    input  logic       hp_limit,
    output logic [2:0] winner
);

    logic lp_any;

    assign lp_any = requests[MASTER_INSTR] | requests[MASTER_DATA];

    always_comb begin
        winner = 3'b000;
        if (requests[MASTER_EXT] && !(hp_limit && lp_any)) begin
            winner[MASTER_EXT] = 1'b1;
        end else if (requests[MASTER_INSTR] && requests[MASTER_DATA]) begin
            // rr_last = 1 means master 2 went last, so master 1 goes now
            if (rr_last) begin
                winner[MASTER_INSTR] = 1'b1;
            end else begin
                winner[MASTER_DATA] = 1'b1;
            end
        end else if (requests[MASTER_INSTR]) begin
            winner[MASTER_INSTR] = 1'b1;
        end else if (requests[MASTER_DATA]) begin
            winner[MASTER_DATA] = 1'b1;
        end
    end

endmodule

// File: rtl/soc_txn_arbiter.sv
// Per-slave arbiter: grants one of three masters and holds it until the slave
// completes, the master abandons, or the wait counter expires.
module soc_txn_arbiter
    import soc_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter int unsigned HP_BURST_MAX   = 8
) (
    input  logic       clk,
    input  logic       res,
    input  logic [2:0] requests,
    input  logic       slave_valid,
    output logic [2:0] grant,
    output logic [1:0] grant_index,
    output logic       grant_any,
    output logic       timeout,
    output logic [1:0] timeout_master
);

    localparam int unsigned WaitW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam int unsigned HpW   = (HP_BURST_MAX > 0) ? $clog2(HP_BURST_MAX + 1) : 1;
    localparam logic [WaitW-1:0] WaitMax = WaitW'(TIMEOUT_CYCLES);
    localparam logic [HpW-1:0]   HpMax   = HpW'(HP_BURST_MAX);

    arb_state_t       state_q;
    logic [2:0]       grant_q;
    logic [1:0]       grant_index_q;
    logic             grant_any_q;
    logic [1:0]       timeout_master_q;
    logic [HpW-1:0]   hp_count_q;
    logic [HpW-1:0]   hp_prev_q;
    logic [WaitW-1:0] wait_q;
    logic             rr_last_q;
    logic             rr_prev_q;

    logic [2:0] arb_req;
    logic [2:0] winner;
    logic       hp_limit;
    logic       lp_pending;
    logic       busy;
    logic       req_held;
    logic       wait_expired;
    logic       timeout_fire;

    // grant_q is zero in IDLE, so one mask serves both arbitration points
    assign arb_req      = requests & ~grant_q;
    assign hp_limit     = (HP_BURST_MAX != 0) && (hp_count_q == HpMax);
    assign lp_pending   = arb_req[MASTER_INSTR] | arb_req[MASTER_DATA];
    assign busy         = (state_q == ARB_BUSY);
    assign req_held     = |(requests & grant_q);
    assign wait_expired = (TIMEOUT_CYCLES != 0) && (wait_q == WaitMax);
    assign timeout_fire = !res && busy && !slave_valid && req_held && wait_expired;

    soc_arb_winner_select u_winner_select (
        .requests (arb_req),
        .rr_last  (rr_last_q),
        .hp_limit (hp_limit),
        .winner   (winner)
    );

    always_ff @(posedge clk) begin
        if (res) begin
            state_q          <= ARB_IDLE;
            grant_q          <= 3'b000;
            grant_index_q    <= MASTER_EXT;
            grant_any_q      <= 1'b0;
            timeout_master_q <= MASTER_EXT;
            hp_count_q       <= '0;
            hp_prev_q        <= '0;
            wait_q           <= '0;
            rr_last_q        <= 1'b1;
            rr_prev_q        <= 1'b1;
        end else begin
            if (timeout_fire) begin
                timeout_master_q <= grant_index_q;
            end
            if (!busy || slave_valid) begin
                if (|winner) begin
                    state_q       <= ARB_BUSY;
                    grant_q       <= winner;
                    grant_index_q <= onehot_to_index(winner);
                    grant_any_q   <= 1'b1;
                    wait_q        <= WaitW'(1);
                    // Snapshot so an abandoned grant leaves no mark on priority
                    hp_prev_q     <= hp_count_q;
                    rr_prev_q     <= rr_last_q;
                    if (winner[MASTER_EXT]) begin
                        if (lp_pending && (hp_count_q != HpMax)) begin
                            hp_count_q <= hp_count_q + 1'b1;
                        end
                    end else begin
                        hp_count_q <= '0;
                        rr_last_q  <= winner[MASTER_DATA];
                    end
                end else begin
                    state_q       <= ARB_IDLE;
                    grant_q       <= 3'b000;
                    grant_index_q <= MASTER_EXT;
                    grant_any_q   <= 1'b0;
                    wait_q        <= '0;
                end
            end else if (!req_held || wait_expired) begin
                state_q       <= ARB_IDLE;
                grant_q       <= 3'b000;
                grant_index_q <= MASTER_EXT;
                grant_any_q   <= 1'b0;
                wait_q        <= '0;
                if (!req_held) begin
                    hp_count_q <= hp_prev_q;
                    rr_last_q  <= rr_prev_q;
                end
            end else if (wait_q != '1) begin
                wait_q <= wait_q + 1'b1;
            end
        end
    end

    assign grant          = grant_q;
    assign grant_index    = grant_index_q;
    assign grant_any      = grant_any_q;
    assign timeout        = timeout_fire;
    assign timeout_master = timeout_fire ? grant_index_q : timeout_master_q;

endmodule

// File: tb/tb_soc_txn_arbiter.sv
// Directed bench for soc_txn_arbiter with TIMEOUT_CYCLES = 4 and HP_BURST_MAX = 2.
module tb_soc_txn_arbiter;

    logic       clk = 1'b0;
    logic       res;
    logic [2:0] requests;
    logic       slave_valid;
    logic [2:0] grant;
    logic [1:0] grant_index;
    logic       grant_any;
    logic       timeout;
    logic [1:0] timeout_master;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    always #5 clk = ~clk;

    soc_txn_arbiter #(
        .TIMEOUT_CYCLES (4),
        .HP_BURST_MAX   (2)
    ) dut (
        .clk            (clk),
        .res            (res),
        .requests       (requests),
        .slave_valid    (slave_valid),
        .grant          (grant),
        .grant_index    (grant_index),
        .grant_any      (grant_any),
        .timeout        (timeout),
        .timeout_master (timeout_master)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic expect_grant(input string tag, input logic [2:0] g, input logic [1:0] idx);
        check({tag, " grant"}, 32'(grant), 32'(g));
        check({tag, " index"}, 32'(grant_index), 32'(idx));
        check({tag, " any"}, 32'(grant_any), 32'(|g));
    endtask

    // Called in the first grant cycle; walks to the timeout pulse and the drop.
    task automatic run_to_timeout(input string tag, input logic [2:0] g, input logic [1:0] m);
        tick();
        check({tag, " no early pulse"}, 32'(timeout), 32'd0);
        tick();
        tick();
        check({tag, " pulse"}, 32'(timeout), 32'd1);
        check({tag, " master"}, 32'(timeout_master), 32'(m));
        check({tag, " grant held"}, 32'(grant), 32'(g));
        tick();
        expect_grant({tag, " dropped"}, 3'b000, 2'd0);
        check({tag, " pulse over"}, 32'(timeout), 32'd0);
        check({tag, " master held"}, 32'(timeout_master), 32'(m));
    endtask

    initial begin
        res         = 1'b1;
        requests    = 3'b000;
        slave_valid = 1'b0;
        tick();
        tick();
        expect_grant("reset", 3'b000, 2'd0);
        check("reset timeout", 32'(timeout), 32'd0);
        check("reset tmaster", 32'(timeout_master), 32'd0);
        res = 1'b0;

        // Master 1 wins first, master 2 follows back-to-back, then idle
        requests = 3'b110;
        tick();
        expect_grant("first rr", 3'b010, 2'd1);
        slave_valid = 1'b1;
        tick();
        expect_grant("b2b m2", 3'b100, 2'd2);
        requests = 3'b000;
        tick();
        expect_grant("back idle", 3'b000, 2'd0);
        slave_valid = 1'b0;

        // Two master-0 grants with master 1 waiting, then master 1 forced in
        for (int r = 0; r < 2; r++) begin
            requests = 3'b011;
            tick();
            expect_grant("hp first m0", 3'b001, 2'd0);
            run_to_timeout("hp to a", 3'b001, 2'd0);
            tick();
            expect_grant("hp second m0", 3'b001, 2'd0);
            run_to_timeout("hp to b", 3'b001, 2'd0);
            tick();
            expect_grant("hp limit m1", 3'b010, 2'd1);
            slave_valid = 1'b1;
            requests    = 3'b000;
            tick();
            expect_grant("hp done", 3'b000, 2'd0);
            slave_valid = 1'b0;
        end

        // Master 1 went last, so master 2 wins; let it time out
        requests = 3'b110;
        tick();
        expect_grant("rr alt m2", 3'b100, 2'd2);
        run_to_timeout("to m2", 3'b100, 2'd2);

        // Valid arriving exactly in the timeout cycle is a completion
        requests = 3'b100;
        tick();
        expect_grant("late valid grant", 3'b100, 2'd2);
        tick();
        tick();
        tick();
        slave_valid = 1'b1;
        #1;
        check("late valid no pulse", 32'(timeout), 32'd0);
        check("late valid grant held", 32'(grant), 32'(3'b100));
        requests = 3'b000;
        tick();
        expect_grant("late valid done", 3'b000, 2'd0);
        check("late valid tmaster", 32'(timeout_master), 32'd2);
        slave_valid = 1'b0;

        // Abandon by master 1 leaves rr_last as it was
        requests = 3'b110;
        tick();
        expect_grant("abandon grant", 3'b010, 2'd1);
        requests = 3'b100;
        tick();
        expect_grant("abandon drop", 3'b000, 2'd0);
        check("abandon no pulse", 32'(timeout), 32'd0);
        requests = 3'b110;
        tick();
        expect_grant("abandon regrant m1", 3'b010, 2'd1);

        // Reset while busy, then normal arbitration right after
        res = 1'b1;
        tick();
        expect_grant("midreset", 3'b000, 2'd0);
        check("midreset timeout", 32'(timeout), 32'd0);
        check("midreset tmaster", 32'(timeout_master), 32'd0);
        res = 1'b0;
        tick();
        expect_grant("post reset", 3'b010, 2'd1);
        slave_valid = 1'b1;
        requests    = 3'b000;
        tick();
        expect_grant("post reset done", 3'b000, 2'd0);
        slave_valid = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
